voting_machine_param: RTL and testbench
=======================================

Name: voting_machine_param

Overview:
Parametrised successor voting machine. It accepts votes for NUM_CAND candidates through push buttons, with a hold-time debounce and one vote per press. Multi-button presses are rejected, and per-candidate counters saturate instead of wrapping. A results mode reports per-candidate counts, the running total, the winner and a tie flag. The block is the top-level vote-tally core, driven directly by board buttons and a mode switch, and it drives the board LEDs.

Parameters:
NUM_CAND, 4, number of candidates/buttons (2..16); IDX_W = clog2(NUM_CAND), derived localparam
CNT_W, 8, per-candidate counter width and LED width
HOLD_CYCLES, 10, consecutive cycles a stable button pattern must be held before it is judged (>=2)
TOT_W, CNT_W+4, total-vote counter width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
mode  in  1  0 = vote, 1 = results
buttons  in  NUM_CAND  button levels, bit i = candidate i
led  out  CNT_W  displayed count
vote_accepted  out  1  one-cycle pulse, vote committed
vote_rejected  out  1  one-cycle pulse, press judged invalid
winner  out  IDX_W  index of leading candidate
tie  out  1  two or more candidates share a nonzero maximum
total_votes  out  TOT_W  sum of accepted votes

Behaviour:
- Reset (sampled at a clock edge): every counter, total_votes, led, winner, tie and both pulses go to 0; the FSM goes to IDLE. A reset arriving mid-press discards the press, and no pulse is produced.
- Press FSM runs only while mode=0. States:
  - IDLE: on buttons!=0, latch the pattern into pat_q, set hold_cnt=1, go to ARM.
  - ARM, buttons==pat_q: hold_cnt increments.
  - ARM, buttons!=pat_q (includes release or change): return to IDLE with no pulse. This is a glitch.
  - ARM, judgement: when hold_cnt==HOLD_CYCLES-1 and buttons==pat_q, judge the pattern at that edge, then go to WAIT_REL.
  - WAIT_REL: stay until buttons==0, then go to IDLE. Holding a button never produces a second vote.
- Judgement (single edge):
  - pat_q one-hot, target counter < 2^CNT_W-1: counter +1, total_votes +1, vote_accepted=1 for the next cycle.
  - pat_q one-hot, target counter saturated: no change, vote_rejected=1.
  - pat_q not one-hot: no change, vote_rejected=1.
  - vote_accepted and vote_rejected are never high together.
- Latency: first nonzero sample at edge k. The counter and the pulse are visible after edge k+HOLD_CYCLES-1.
- total_votes saturates at 2^TOT_W-1, independently of the per-candidate counters.
- mode=1:
  - The FSM is forced to IDLE at the next edge, and any ARM in progress is aborted with no pulse.
  - No votes are taken.
  - led is registered and shows the count of the lowest-index pressed button. With no button pressed, led holds its last value.
  - Returning to mode=0: led is 0 from the next edge. While buttons are still held, the FSM stays in WAIT_REL until release, so no vote is taken on the mode edge.
- mode=0: led is 0.
- winner and tie are registered and recomputed every cycle from the counters, so they lag a counter update by 1 cycle.
  - winner = lowest index among candidates holding the maximum count.
  - tie = 1 iff the maximum is > 0 and at least 2 candidates hold it.
  - All counters 0: winner=0, tie=0.

Test Plan:
- Single valid vote: reset 2 cycles, mode=0, buttons=4'b0001 held 20 cycles, then 0 → cand0=1, total_votes=1, one vote_accepted pulse 9 cycles after the first press sample, winner=0, tie=0.
- Glitch and hold: buttons=4'b0010 for 5 cycles → no change, no pulse. Then 4'b0010 for 200 cycles → exactly 1 vote for cand1.
- Multi-press: buttons=4'b0110 for 20 cycles → one vote_rejected pulse, all counts unchanged.
- Results and tie: after cand0=1 and cand1=1, mode=1, buttons=4'b0010 → led=8'h01, winner=0, tie=1. Then mode=1, buttons=4'b0100 → led=8'h00. A press on the mode 1→0 edge yields no vote.
- Saturation: CNT_W=2; 4 valid presses of button3 → cand3=3, 4th press gives vote_rejected, total_votes=3.
- Reset mid-press: buttons=4'b1000 held, reset asserted at hold_cnt=5 → all outputs 0, no pulse. A subsequent release and clean press → cand3=1.

Source files
------------

// File: rtl/voting_machine_param.sv
// voting_machine_param: push-button vote tally core.
// Buttons are debounced by a hold-time FSM, and each press yields at most one judgement.
// Per-candidate and total counters saturate. A results mode drives the LEDs with the
// count of the lowest-index pressed button. Winner and tie flags are registered.
module voting_machine_param #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10,
    parameter int TOT_W       = CNT_W + 4,
    localparam int IDX_W      = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] buttons,
    output logic [CNT_W-1:0]    led,
    output logic                vote_accepted,
    output logic                vote_rejected,
    output logic [IDX_W-1:0]    winner,
    output logic                tie,
    output logic [TOT_W-1:0]    total_votes
);

    localparam int HC_W = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CAND-1:0] pat_q, pat_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                mode_q;
    logic                judge;

    logic [CNT_W-1:0]    cnt_q [NUM_CAND];

    logic [IDX_W-1:0]    acc_idx;
    logic                pat_onehot;
    logic                target_sat;
    logic                accept_d;
    logic                reject_d;

    logic [IDX_W-1:0]    win_d;
    logic                tie_d;
    logic [CNT_W-1:0]    max_v;
    logic                max_seen;

    // True when exactly one bit of the pattern is set.
    function automatic logic is_onehot(input logic [NUM_CAND-1:0] p);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (p[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return seen & ~multi;
    endfunction

    // Index of the set bit of a one-hot pattern.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_CAND-1:0] p);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (p[i]) r = r | IDX_W'(i);
        end
        return r;
    endfunction

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CAND-1:0] p);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (p[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Saturating increment of a candidate counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Saturating increment of the running total.
    function automatic logic [TOT_W-1:0] tot_sat_inc(input logic [TOT_W-1:0] v);
        return (v == '1) ? v : v + TOT_W'(1);
    endfunction

    // Press FSM next state: debounce, judge once, then wait for release.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hold_d  = hold_q;
        judge   = 1'b0;
        if (mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (buttons != '0) begin
                        // A button still held from results mode must be released first.
                        if (mode_q) begin
                            state_d = WAIT_REL;
                        end else begin
                            pat_d   = buttons;
                            hold_d  = HC_W'(1);
                            state_d = ARM;
                        end
                    end
                end
                ARM: begin
                    if (buttons != pat_q) begin
                        state_d = IDLE;
                    end else if (hold_q == HC_W'(HOLD_CYCLES - 1)) begin
                        judge   = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (buttons == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Judgement of the latched pattern: accept only a one-hot press on a non-saturated counter.
    always_comb begin
        acc_idx    = onehot_idx(pat_q);
        pat_onehot = is_onehot(pat_q);
        target_sat = (cnt_q[acc_idx] == '1);
        accept_d   = judge & pat_onehot & ~target_sat;
        reject_d   = judge & ~accept_d;
    end

    // Leader scan over the counters: lowest index wins, tie needs a shared nonzero maximum.
    always_comb begin
        max_v    = cnt_q[0];
        win_d    = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (cnt_q[i] > max_v) begin
                max_v = cnt_q[i];
                win_d = IDX_W'(i);
            end
        end
        tie_d    = 1'b0;
        max_seen = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] == max_v) begin
                if (max_seen) tie_d = 1'b1;
                max_seen = 1'b1;
            end
        end
        if (max_v == '0) tie_d = 1'b0;
    end

    // FSM state, latched pattern, hold counter and previous mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            mode_q  <= mode;
        end
    end

    // Per-candidate vote counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
        end else if (accept_d) begin
            cnt_q[acc_idx] <= cnt_sat_inc(cnt_q[acc_idx]);
        end
    end

    // Running total and the one-cycle judgement pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            total_votes   <= '0;
            vote_accepted <= 1'b0;
            vote_rejected <= 1'b0;
        end else begin
            if (accept_d) total_votes <= tot_sat_inc(total_votes);
            vote_accepted <= accept_d;
            vote_rejected <= reject_d;
        end
    end

    // LED display: dark in vote mode, lowest pressed candidate's count in results mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else if (!mode) begin
            led <= '0;
        end else if (buttons != '0) begin
            led <= cnt_q[lowest_idx(buttons)];
        end
    end

    // Registered winner and tie flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            winner <= win_d;
            tie    <= tie_d;
        end
    end

endmodule

// File: tb/tb_voting_machine_param.sv
// Bench for voting_machine_param: directed scenarios plus random presses,
// checked every cycle against a behavioural tally model.
module tb_voting_machine_param;

    localparam int NC   = 4;
    localparam int CW   = 2;
    localparam int HC   = 10;
    localparam int TW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          mode;
    logic [NC-1:0] buttons;
    logic [CW-1:0] led;
    logic          vote_accepted;
    logic          vote_rejected;
    logic [1:0]    winner;
    logic          tie;
    logic [TW-1:0] total_votes;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int            m_cnt [NC];
    int            m_total;
    int            m_led;
    int            m_win;
    bit            m_tie;
    bit            m_acc;
    bit            m_rej;
    int            run;
    bit            spent;
    bit            was_res;
    logic [NC-1:0] cur;

    int acc_seen;
    int rej_seen;

    voting_machine_param #(
        .NUM_CAND   (NC),
        .CNT_W      (CW),
        .HOLD_CYCLES(HC),
        .TOT_W      (TW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .buttons      (buttons),
        .led          (led),
        .vote_accepted(vote_accepted),
        .vote_rejected(vote_rejected),
        .winner       (winner),
        .tie          (tie),
        .total_votes  (total_votes)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of the tally rules: a press counts once it has been seen HC samples in a row.
    task automatic model_step(input bit r, input bit m, input logic [NC-1:0] b);
        int mx;
        int w;
        int lo;
        int idx;
        bit found;
        bit tie_v;
        if (r) begin
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            m_total = 0; m_led = 0; m_win = 0; m_tie = 0; m_acc = 0; m_rej = 0;
            run = 0; spent = 0; was_res = 0; cur = '0;
            return;
        end
        mx = m_cnt[0];
        w  = 0;
        for (int i = 1; i < NC; i++) if (m_cnt[i] > mx) begin mx = m_cnt[i]; w = i; end
        found = 0;
        tie_v = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) begin if (found) tie_v = 1; found = 1; end
        m_win = w;
        m_tie = tie_v && (mx > 0);
        m_acc = 0;
        m_rej = 0;
        if (m) begin
            run = 0; spent = 0; was_res = 1;
            if (b != '0) begin
                lo = 0;
                while (!b[lo]) lo++;
                m_led = m_cnt[lo];
            end
        end else begin
            m_led = 0;
            if (spent) begin
                if (b == '0) spent = 0;
            end else if (run == 0) begin
                if (b != '0) begin
                    if (was_res) spent = 1;
                    else begin cur = b; run = 1; end
                end
            end else if (b != cur) begin
                run = 0;
            end else begin
                run++;
                if (run == HC) begin
                    run   = 0;
                    spent = 1;
                    if ($countones(cur) == 1) begin
                        idx = 0;
                        while (!cur[idx]) idx++;
                        if (m_cnt[idx] < CMAX) begin
                            m_cnt[idx]++;
                            if (m_total < TMAX) m_total++;
                            m_acc = 1;
                        end else begin
                            m_rej = 1;
                        end
                    end else begin
                        m_rej = 1;
                    end
                end
            end
            was_res = 0;
        end
    endtask

    // Drive one cycle, advance the model, then compare every output after the edge.
    task automatic cycle(input bit r, input bit m, input logic [NC-1:0] b);
        reset   = r;
        mode    = m;
        buttons = b;
        model_step(r, m, b);
        @(posedge clock);
        #2;
        check("led", int'(led), m_led);
        check("winner", int'(winner), m_win);
        check("tie", int'(tie), int'(m_tie));
        check("total_votes", int'(total_votes), m_total);
        check("vote_accepted", int'(vote_accepted), int'(m_acc));
        check("vote_rejected", int'(vote_rejected), int'(m_rej));
        acc_seen += int'(vote_accepted);
        rej_seen += int'(vote_rejected);
    endtask

    task automatic hold(input bit m, input logic [NC-1:0] b, input int n);
        repeat (n) cycle(1'b0, m, b);
    endtask

    initial begin
        logic [NC-1:0] p;
        logic [NC-1:0] q;
        int            sel;
        int            len;

        acc_seen = 0;
        rej_seen = 0;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("reset_total", int'(total_votes), 0);
        check("reset_led", int'(led), 0);

        // Single valid vote: pulse after the tenth consecutive sample
        acc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 4'b0001);
            check("acc_timing", int'(vote_accepted), (i == 9) ? 1 : 0);
        end
        hold(1'b0, 4'b0000, 3);
        check("single_total", int'(total_votes), 1);
        check("single_pulses", acc_seen, 1);
        check("single_winner", int'(winner), 0);
        check("single_tie", int'(tie), 0);

        // Glitch shorter than the hold time, then a long hold
        acc_seen = 0; rej_seen = 0;
        hold(1'b0, 4'b0010, 5);
        hold(1'b0, 4'b0000, 3);
        check("glitch_total", int'(total_votes), 1);
        check("glitch_pulses", acc_seen + rej_seen, 0);
        hold(1'b0, 4'b0010, 200);
        hold(1'b0, 4'b0000, 3);
        check("longhold_total", int'(total_votes), 2);
        check("longhold_pulses", acc_seen, 1);
        check("two_way_tie", int'(tie), 1);

        // Multi-button press is rejected once
        acc_seen = 0; rej_seen = 0;
        hold(1'b0, 4'b0110, 20);
        hold(1'b0, 4'b0000, 3);
        check("multi_rej", rej_seen, 1);
        check("multi_acc", acc_seen, 0);
        check("multi_total", int'(total_votes), 2);

        // Results mode
        hold(1'b1, 4'b0010, 2);
        check("res_led_c1", int'(led), 1);
        check("res_winner", int'(winner), 0);
        check("res_tie", int'(tie), 1);
        hold(1'b1, 4'b0100, 2);
        check("res_led_c2", int'(led), 0);
        hold(1'b1, 4'b0001, 1);
        hold(1'b1, 4'b0000, 2);
        check("res_led_hold", int'(led), 1);
        hold(1'b1, 4'b0100, 2);
        acc_seen = 0; rej_seen = 0;
        hold(1'b0, 4'b0100, 20);
        check("mode_edge_pulses", acc_seen + rej_seen, 0);
        check("mode_edge_total", int'(total_votes), 2);
        check("vote_mode_led", int'(led), 0);
        hold(1'b0, 4'b0000, 3);

        // Saturation of candidate 3 at CMAX
        cycle(1'b1, 1'b0, '0);
        acc_seen = 0; rej_seen = 0;
        repeat (4) begin
            hold(1'b0, 4'b1000, 12);
            hold(1'b0, 4'b0000, 2);
        end
        check("sat_acc", acc_seen, 3);
        check("sat_rej", rej_seen, 1);
        check("sat_total", int'(total_votes), 3);
        hold(1'b1, 4'b1000, 2);
        check("sat_led", int'(led), 3);
        check("sat_winner", int'(winner), 3);
        hold(1'b0, 4'b0000, 2);

        // Reset in the middle of a press
        acc_seen = 0; rej_seen = 0;
        hold(1'b0, 4'b1000, 5);
        cycle(1'b1, 1'b0, 4'b1000);
        check("midrst_total", int'(total_votes), 0);
        check("midrst_winner", int'(winner), 0);
        check("midrst_pulses", acc_seen + rej_seen, 0);
        hold(1'b0, 4'b0000, 2);
        hold(1'b0, 4'b1000, 12);
        hold(1'b0, 4'b0000, 2);
        check("postrst_acc", acc_seen, 1);
        check("postrst_total", int'(total_votes), 1);
        hold(1'b1, 4'b1000, 2);
        check("postrst_led", int'(led), 1);
        hold(1'b0, 4'b0000, 2);

        // Random presses, glitches, results-mode visits and resets
        for (int e = 0; e < 300; e++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                cycle(1'b1, 1'b0, NC'($urandom_range(0, (1 << NC) - 1)));
            end else if (sel < 14) begin
                len = $urandom_range(1, 6);
                repeat (len) cycle(1'b0, 1'b1, NC'($urandom_range(0, (1 << NC) - 1)));
            end else begin
                if ($urandom_range(0, 3) != 0) p = NC'(1) << $urandom_range(0, NC - 1);
                else p = NC'($urandom_range(1, (1 << NC) - 1));
                case ($urandom_range(0, 2))
                    0:       len = $urandom_range(1, HC - 1);
                    1:       len = HC;
                    default: len = $urandom_range(HC, HC + 15);
                endcase
                hold(1'b0, p, len);
                if ($urandom_range(0, 4) == 0) begin
                    q = NC'(1) << $urandom_range(0, NC - 1);
                    hold(1'b0, q, $urandom_range(1, HC + 3));
                end
            end
            hold(1'b0, 4'b0000, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
